vga_timing_ctrl: RTL and testbench

Raster timing controller for the 640x480@60 Hz VGA output path (25.175/25 MHz pixel clock). Generates horizontal/vertical counters, requests pixels from the downstream-of-timing data generator via `pix_x`/`pix_y` one cycle ahead of display, and returns its registered 16-bit RGB565 `pix_data` to the monitor together with the sync signals. It sits between the pixel clock domain and the VGA DAC/pins; every pattern/data generator plugs into its `pix_x`/`pix_y`/`pix_data` port.

---
 rtl/vga_pkg.sv | 24 ++
 rtl/vga_raster_cnt.sv | 37 +++
 rtl/vga_timing_ctrl.sv | 89 ++++++++
 tb/tb_vga_timing_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 Hz raster constants, reused by the timing controller
// and by every pixel data generator that plugs into it.
package vga_pkg;

   localparam int H_SYNC  = 96;
   localparam int H_BACK  = 48;
   localparam int H_VALID = 640;
   localparam int H_FRONT = 16;
   localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;

   localparam int V_SYNC  = 2;
   localparam int V_BACK  = 33;
   localparam int V_VALID = 480;
   localparam int V_FRONT = 10;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

   // Counter / coordinate width and pixel width
   localparam int PIX_W = 10;
   localparam int RGB_W = 16;

   // Coordinate value presented when no pixel is being requested
   localparam logic [PIX_W-1:0] PIX_INVALID = 10'h3ff;

endpackage

// File: rtl/vga_raster_cnt.sv
// Horizontal/vertical raster counters. cnt_h runs 0..H_TOTAL-1 every clock,
// cnt_v advances on the last clock of each line and wraps on the last line.
module vga_raster_cnt
   import vga_pkg::*;
#(
   parameter int H_TOTAL = vga_pkg::H_TOTAL,
   parameter int V_TOTAL = vga_pkg::V_TOTAL
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [PIX_W-1:0] cnt_h,
   output logic [PIX_W-1:0] cnt_v
);

   localparam logic [PIX_W-1:0] H_LAST = PIX_W'(H_TOTAL - 1);
   localparam logic [PIX_W-1:0] V_LAST = PIX_W'(V_TOTAL - 1);

   logic line_end;
   logic frame_end;

   assign line_end  = (cnt_h == H_LAST);
   assign frame_end = line_end && (cnt_v == V_LAST);

   // Advance the raster position; both counters wrap together at frame end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_h <= '0;
         cnt_v <= '0;
      end else if (line_end) begin
         cnt_h <= '0;
         cnt_v <= frame_end ? '0 : cnt_v + 1'b1;
      end else begin
         cnt_h <= cnt_h + 1'b1;
      end
   end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing controller: requests pixels one clock ahead of display
// through pix_x/pix_y, then registers sync, display-enable and the returned
// pixel data together so all monitor-side outputs stay mutually aligned.
module vga_timing_ctrl
   import vga_pkg::*;
#(
   parameter int H_SYNC_CLKS   = vga_pkg::H_SYNC,
   parameter int H_BACK_CLKS   = vga_pkg::H_BACK,
   parameter int H_VALID_PIX   = vga_pkg::H_VALID,
   parameter int H_FRONT_CLKS  = vga_pkg::H_FRONT,
   parameter int V_SYNC_LINES  = vga_pkg::V_SYNC,
   parameter int V_BACK_LINES  = vga_pkg::V_BACK,
   parameter int V_VALID_LINES = vga_pkg::V_VALID,
   parameter int V_FRONT_LINES = vga_pkg::V_FRONT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [RGB_W-1:0] pix_data,
   output logic [PIX_W-1:0] pix_x,
   output logic [PIX_W-1:0] pix_y,
   output logic             vga_hs,
   output logic             vga_vs,
   output logic             vga_de,
   output logic [RGB_W-1:0] vga_rgb,
   output logic             frame_start
);

   localparam int H_TOT = H_SYNC_CLKS + H_BACK_CLKS + H_VALID_PIX + H_FRONT_CLKS;
   localparam int V_TOT = V_SYNC_LINES + V_BACK_LINES + V_VALID_LINES + V_FRONT_LINES;
   localparam int H_ACT = H_SYNC_CLKS + H_BACK_CLKS;
   localparam int V_ACT = V_SYNC_LINES + V_BACK_LINES;

   localparam logic [PIX_W-1:0] H_SYNC_END  = PIX_W'(H_SYNC_CLKS);
   localparam logic [PIX_W-1:0] H_ACT_START = PIX_W'(H_ACT);
   localparam logic [PIX_W-1:0] H_ACT_END   = PIX_W'(H_ACT + H_VALID_PIX);
   // Request window is the active window shifted one clock earlier, so the
   // generator's registered answer lands exactly on the active pixel.
   localparam logic [PIX_W-1:0] H_REQ_START = PIX_W'(H_ACT - 1);
   localparam logic [PIX_W-1:0] H_REQ_END   = PIX_W'(H_ACT + H_VALID_PIX - 1);
   localparam logic [PIX_W-1:0] V_SYNC_END  = PIX_W'(V_SYNC_LINES);
   localparam logic [PIX_W-1:0] V_ACT_START = PIX_W'(V_ACT);
   localparam logic [PIX_W-1:0] V_ACT_END   = PIX_W'(V_ACT + V_VALID_LINES);

   logic [PIX_W-1:0] cnt_h;
   logic [PIX_W-1:0] cnt_v;
   logic             h_active;
   logic             h_request;
   logic             v_active;
   logic             active;
   logic             req_win;

   vga_raster_cnt #(
      .H_TOTAL (H_TOT),
      .V_TOTAL (V_TOT)
   ) u_raster_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .cnt_h (cnt_h),
      .cnt_v (cnt_v)
   );

   assign h_active  = (cnt_h >= H_ACT_START) && (cnt_h < H_ACT_END);
   assign h_request = (cnt_h >= H_REQ_START) && (cnt_h < H_REQ_END);
   assign v_active  = (cnt_v >= V_ACT_START) && (cnt_v < V_ACT_END);
   assign active    = h_active && v_active;
   assign req_win   = h_request && v_active;

   // Coordinates never underflow inside the window, so 10-bit subtraction is safe
   assign pix_x = req_win ? (cnt_h - H_REQ_START) : PIX_INVALID;
   assign pix_y = req_win ? (cnt_v - V_ACT_START) : PIX_INVALID;

   // Output stage: one register delay for every monitor-side signal
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         vga_de      <= 1'b0;
         vga_rgb     <= '0;
         frame_start <= 1'b0;
      end else begin
         vga_hs      <= !(cnt_h < H_SYNC_END);
         vga_vs      <= !(cnt_v < V_SYNC_END);
         vga_de      <= active;
         vga_rgb     <= active ? pix_data : '0;
         frame_start <= active && (cnt_h == H_ACT_START) && (cnt_v == V_ACT_START);
      end
   end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl. Horizontal timing is the real 800-clock line;
// the vertical back porch / active / front porch are shortened (3/4/2 lines)
// so several whole frames fit in a short run. Expected values come from a
// bench-side raster position counter and hand-derived constants; a
// scoreboard queue holds the pixel expected for every request and a monitor
// pops it whenever vga_de is presented.
module tb_vga_timing_ctrl;

   localparam int HS = 96, HB = 48, HV = 640, HF = 16, HT = 800;
   localparam int VS = 2, VB = 3, VV = 4, VF = 2, VT = 11;
   localparam int HA = 144, VA = 5;
   localparam int FRAME = HT * VT;   // 8800 clocks

   typedef struct {
      logic [9:0]  x;
      logic [9:0]  y;
      logic [15:0] rgb;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] pix_data = 16'hffff;
   logic [9:0]  pix_x, pix_y;
   logic        vga_hs, vga_vs, vga_de, frame_start;
   logic [15:0] vga_rgb;

   int   tests = 0;
   int   fails = 0;
   int   c;                 // clocks since reset release = raster position
   bit   chk_en = 1'b0;
   bit   gen_const = 1'b1;  // 1: generator returns 16'hffff, 0: coordinate pattern
   logic [15:0] gen_next = 16'hffff;
   exp_t expq[$];

   vga_timing_ctrl #(
      .H_SYNC_CLKS   (HS),
      .H_BACK_CLKS   (HB),
      .H_VALID_PIX   (HV),
      .H_FRONT_CLKS  (HF),
      .V_SYNC_LINES  (VS),
      .V_BACK_LINES  (VB),
      .V_VALID_LINES (VV),
      .V_FRONT_LINES (VF)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pix_data    (pix_data),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .vga_hs      (vga_hs),
      .vga_vs      (vga_vs),
      .vga_de      (vga_de),
      .vga_rgb     (vga_rgb),
      .frame_start (frame_start)
   );

   always #20 clk = ~clk;

   function automatic logic [15:0] pat(input logic [9:0] x, input logic [9:0] y);
      return {y[4:0], x[5:0], x[4:0]};
   endfunction

   function automatic int hpos(input int p);
      return p % HT;
   endfunction

   function automatic int vpos(input int p);
      return (p / HT) % VT;
   endfunction

   function automatic bit act(input int p);
      return hpos(p) >= HA && hpos(p) < HA + HV && vpos(p) >= VA && vpos(p) < VA + VV;
   endfunction

   function automatic bit req(input int p);
      return hpos(p) >= HA - 1 && hpos(p) <= HA + HV - 2 && vpos(p) >= VA && vpos(p) < VA + VV;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h (pos %0d)", name, got, exp, c);
      end
   endtask

   // Bench raster position: async cleared like the DUT, +1 per clock
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) c <= 0;
      else        c <= c + 1;
   end

   // Behavioural data generator: answers a request one clock later
   always @(negedge clk) begin
      pix_data = gen_next;
      gen_next = gen_const ? 16'hffff : pat(pix_x, pix_y);
   end

   // Per-clock raster check plus scoreboard push for each pixel request
   always @(negedge clk) begin : chk_blk
      int          q, h, v;
      logic [9:0]  ex, ey;
      logic        e_hs, e_vs, e_de, e_fs;
      exp_t        item;
      if (chk_en && rst_n) begin
         if (req(c)) begin
            ex = 10'(hpos(c) - (HA - 1));
            ey = 10'(vpos(c) - VA);
         end else begin
            ex = 10'h3ff;
            ey = 10'h3ff;
         end
         if (c == 0) begin
            e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_fs = 1'b0;
         end else begin
            q = c - 1;
            h = hpos(q);
            v = vpos(q);
            e_hs = !(h < HS);
            e_vs = !(v < VS);
            e_de = act(q);
            e_fs = e_de && h == HA && v == VA;
         end
         check("raster", {pix_x, pix_y, vga_hs, vga_vs, vga_de, frame_start},
               {ex, ey, e_hs, e_vs, e_de, e_fs});
         if (!vga_de) check("rgb_blank", vga_rgb, 16'h0);
         if (req(c)) begin
            item.x = ex;
            item.y = ey;
            item.rgb = gen_const ? 16'hffff : pat(ex, ey);
            expq.push_back(item);
         end
      end
   end

   // Monitor: every displayed pixel must match the oldest outstanding request
   always @(negedge clk) begin : mon_blk
      exp_t e;
      if (chk_en && rst_n && vga_de) begin
         if (expq.size() == 0) begin
            check("sb_underflow", 1, 0);
         end else begin
            e = expq.pop_front();
            check("rgb_pixel", vga_rgb, e.rgb);
            if ((e.x == 0 || e.x == HV - 1) && (e.y == 0 || e.y == VV - 1))
               $display("[TB] corner pixel x=%0d y=%0d rgb=%04h expected %04h",
                        e.x, e.y, vga_rgb, e.rgb);
         end
      end
   end

   initial begin : main
      int   de_cnt, vs_low, hs_low, fs_cnt, hs_falls, hs_run, last_fall, vs_fall_c;
      int   de2, n;
      logic prev_hs, prev_vs;
      bit   seen;

      // Reset held 10 clocks with generator driving all-ones
      gen_const = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("rst_rgb", vga_rgb, 16'h0);
      check("rst_hs", vga_hs, 1'b1);
      check("rst_vs", vga_vs, 1'b1);
      check("rst_de", vga_de, 1'b0);
      check("rst_fs", frame_start, 1'b0);
      check("rst_pix_x", pix_x, 10'h3ff);
      check("rst_pix_y", pix_y, 10'h3ff);
      $display("[TB] reset values checked");

      // Frame 1: coordinate pattern, measure sync geometry over one frame
      gen_const = 1'b0;
      rst_n = 1'b1;
      chk_en = 1'b1;
      de_cnt = 0; vs_low = 0; hs_low = 0; fs_cnt = 0; hs_falls = 0; hs_run = 0;
      last_fall = -1; vs_fall_c = -1;
      prev_hs = 1'b1; prev_vs = 1'b1;
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         if (vga_de) de_cnt++;
         if (!vga_vs) vs_low++;
         if (!vga_hs) begin hs_low++; hs_run++; end
         if (frame_start) begin
            fs_cnt++;
            check("fs_first_de", de_cnt, 1);
         end
         if (prev_hs && !vga_hs) begin
            hs_falls++;
            if (last_fall >= 0) check("hs_period", c - last_fall, HT);
            last_fall = c;
         end
         if (!prev_hs && vga_hs) begin
            check("hs_width", hs_run, HS);
            hs_run = 0;
         end
         if (prev_vs && !vga_vs) begin
            check("vs_on_hs_fall", {prev_hs, vga_hs}, 2'b10);
            vs_fall_c = c;
         end
         prev_hs = vga_hs;
         prev_vs = vga_vs;
      end
      check("de_count", de_cnt, HV * VV);
      check("fs_count", fs_cnt, 1);
      check("vs_low", vs_low, VS * HT);
      check("hs_low_total", hs_low, HS * VT);
      check("hs_falls", hs_falls, VT);
      $display("[TB] frame 1 pattern: de=%0d vs_low=%0d hs_falls=%0d fs=%0d",
               de_cnt, vs_low, hs_falls, fs_cnt);

      // Frame 2: generator held at 16'hffff, checks blanking stays zero
      gen_const = 1'b1;
      de2 = 0;
      seen = 1'b0;
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         if (vga_de) de2++;
         if (prev_vs && !vga_vs && !seen) begin
            check("vs_period", c - vs_fall_c, FRAME);
            seen = 1'b1;
         end
         prev_vs = vga_vs;
      end
      check("vs_period_seen", seen, 1'b1);
      check("de_count_ffff", de2, HV * VV);
      $display("[TB] frame 2 constant data: de=%0d", de2);

      // Frame 3: pattern again, reset asynchronously at line 7 pixel 300
      gen_const = 1'b0;
      repeat (7 * HT + HA + 300) @(negedge clk);
      check("de_before_rst", vga_de, 1'b1);
      #5;
      rst_n = 1'b0;
      chk_en = 1'b0;
      #1;
      check("arst_de", vga_de, 1'b0);
      check("arst_rgb", vga_rgb, 16'h0);
      check("arst_hs", vga_hs, 1'b1);
      check("arst_vs", vga_vs, 1'b1);
      check("arst_pix_x", pix_x, 10'h3ff);
      check("arst_pix_y", pix_y, 10'h3ff);
      $display("[TB] async reset mid-frame checked");
      repeat (3) @(negedge clk);
      expq.delete();
      rst_n = 1'b1;
      chk_en = 1'b1;

      n = 0;
      seen = 1'b0;
      while (n < 3 * FRAME && !seen) begin
         @(negedge clk);
         n++;
         if (frame_start) seen = 1'b1;
      end
      check("fs_after_rst_seen", seen, 1'b1);
      check("fs_after_rst_delay", n, VA * HT + HA + 1);
      $display("[TB] frame_start %0d clocks after reset release", n);

      // Let the first line drain so every request has been displayed
      repeat (700) @(negedge clk);
      check("sb_drain", expq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
